// File: rtl/ecc_pkg.sv
// Shared types and constant helpers for the ECC scrubber and its Hamming SECDED codec.
package ecc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        CHECK,
        WR_REQ,
        NEXT,
        DONE
    } scrub_state_e;

    // Smallest m with 2**m >= m + k + 1 (Hamming check bits for k data bits).
    function automatic int calc_m(input int k);
        int m;
        m = 1;
        for (int i = 30; i >= 1; i--) begin
            if ((1 << i) >= i + k + 1) m = i;
        end
        return m;
    endfunction

    // Codeword positions 1..cw-1 whose index has any bit of bitv set.
    function automatic logic [63:0] cover_mask(input int bitv, input int cw);
        logic [63:0] msk;
        msk = '0;
        for (int q = 1; q < 64; q++) begin
            if (q < cw && (q & bitv) != 0) msk[q] = 1'b1;
        end
        return msk;
    endfunction

endpackage

// File: rtl/hamming_dec.sv
// SECDED decoder matching hamming_enc: corrects any single-bit error and
// flags double-bit errors (or syndromes pointing outside the codeword).
module hamming_dec
    import ecc_pkg::*;
#(
    parameter  int K  = 4,
    localparam int M  = calc_m(K),
    localparam int CW = M + K + 1
) (
    input  logic [CW-1:0] code_i,
    output logic [K-1:0]  data_o,
    output logic          sb_err_o,
    output logic          db_err_o
);

    logic [M-1:0]  syn;
    logic          par;
    logic [CW-1:0] flip;
    logic [CW-1:0] fixed;

    for (genvar i = 0; i < M; i++) begin : g_syn
        localparam logic [63:0] CMASK = cover_mask(1 << i, CW);
        assign syn[i] = ^(code_i & CMASK[CW-1:0]);
    end

    assign par = ^code_i;

    // Syndrome 0 with bad parity means the overall parity bit itself flipped.
    for (genvar p = 0; p < CW; p++) begin : g_flip
        assign flip[p] = par && (syn == M'(p));
    end

    assign fixed = code_i ^ flip;

    for (genvar p = 1; p < CW; p++) begin : g_gather
        if ((p & (p - 1)) != 0) begin : g_data
            assign data_o[p - 1 - $clog2(p + 1)] = fixed[p];
        end
    end

    assign sb_err_o = par && (int'(syn) < CW);
    assign db_err_o = (!par && (syn != '0)) || (par && (int'(syn) >= CW));

endmodule

// File: rtl/hamming_enc.sv
// SECDED encoder: bit 0 is overall parity, bits 1..CW-1 are Hamming positions
// with check bits at powers of two and data filling the rest in ascending order.
module hamming_enc
    import ecc_pkg::*;
#(
    parameter  int K  = 4,
    localparam int M  = calc_m(K),
    localparam int CW = M + K + 1
) (
    input  logic [K-1:0]  data_i,
    output logic [CW-1:0] code_o
);

    logic [CW-1:0] dvec;

    assign dvec[0] = 1'b0;
    for (genvar p = 1; p < CW; p++) begin : g_scatter
        if ((p & (p - 1)) != 0) begin : g_data
            assign dvec[p] = data_i[p - 1 - $clog2(p + 1)];
        end else begin : g_chk
            assign dvec[p] = 1'b0;
        end
    end

    for (genvar p = 1; p < CW; p++) begin : g_code
        if ((p & (p - 1)) != 0) begin : g_data
            assign code_o[p] = dvec[p];
        end else begin : g_chk
            localparam logic [63:0] CMASK = cover_mask(p, CW);
            assign code_o[p] = ^(dvec & CMASK[CW-1:0]);
        end
    end

    assign code_o[0] = ^code_o[CW-1:1];

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Memory scrubber: reads each word, corrects single-bit errors by write-back,
// counts/locates uncorrectable words. Define ECC_SCRUB_IRQ_EN for a sticky irq_o.
module ecc_scrub_ctrl
    import ecc_pkg::*;
#(
    parameter  int K     = 4,
    parameter  int DEPTH = 16,
    parameter  int CNT_W = 8,
    localparam int M     = calc_m(K),
    localparam int CW    = M + K + 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [AW-1:0]    mem_addr_o,
    output logic [CW-1:0]    mem_wdata_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [CW-1:0]    mem_rdata_i,
    output logic [CNT_W-1:0] sb_cnt_o,
    output logic [CNT_W-1:0] db_cnt_o,
    output logic [AW-1:0]    db_addr_o,
    output logic             irq_o
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    scrub_state_e     state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [CW-1:0]    rdata_q, rdata_d;
    logic [CW-1:0]    wdata_q, wdata_d;
    logic [CNT_W-1:0] sb_cnt_q, sb_cnt_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [AW-1:0]    db_addr_q, db_addr_d;
    logic             abort_q, abort_d;

    logic [K-1:0]     dec_data;
    logic             dec_sb, dec_db;
    logic [CW-1:0]    enc_code;

    hamming_dec #(.K(K)) u_dec (
        .code_i   (rdata_q),
        .data_o   (dec_data),
        .sb_err_o (dec_sb),
        .db_err_o (dec_db)
    );

    hamming_enc #(.K(K)) u_enc (
        .data_i (dec_data),
        .code_o (enc_code)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        wdata_d   = wdata_q;
        sb_cnt_d  = sb_cnt_q;
        db_cnt_d  = db_cnt_q;
        db_addr_d = db_addr_q;
        abort_d   = abort_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = RD_REQ;
                    addr_d    = '0;
                    sb_cnt_d  = '0;
                    db_cnt_d  = '0;
                    db_addr_d = '0;
                    abort_d   = 1'b0;
                end
            end
            RD_REQ: begin
                if (abort_i)        state_d = DONE;
                else if (mem_gnt_i) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // An abort here still lets the outstanding read land and be counted.
                if (abort_i) abort_d = 1'b1;
                if (mem_rvalid_i) begin
                    rdata_d = mem_rdata_i;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                wdata_d = enc_code;
                if (dec_sb && sb_cnt_q != '1) sb_cnt_d = sb_cnt_q + 1'b1;
                if (dec_db) begin
                    if (db_cnt_q != '1) db_cnt_d = db_cnt_q + 1'b1;
                    if (db_cnt_q == '0) db_addr_d = addr_q;
                end
                if (abort_i || abort_q) state_d = DONE;
                else if (dec_sb)        state_d = WR_REQ;
                else                    state_d = NEXT;
            end
            WR_REQ: begin
                if (abort_i) abort_d = 1'b1;
                if (mem_gnt_i) state_d = (abort_i || abort_q) ? DONE : NEXT;
            end
            NEXT: begin
                if (abort_i || abort_q || addr_q == LAST) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = RD_REQ;
                end
            end
            DONE: begin
                abort_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rdata_q   <= '0;
            wdata_q   <= '0;
            sb_cnt_q  <= '0;
            db_cnt_q  <= '0;
            db_addr_q <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rdata_q   <= rdata_d;
            wdata_q   <= wdata_d;
            sb_cnt_q  <= sb_cnt_d;
            db_cnt_q  <= db_cnt_d;
            db_addr_q <= db_addr_d;
            abort_q   <= abort_d;
        end
    end

`ifdef ECC_SCRUB_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        if (state_q == IDLE && start_i)      irq_d = 1'b0;
        else if (state_q == CHECK && dec_db) irq_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) irq_q <= 1'b0;
        else         irq_q <= irq_d;
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    assign busy_o      = (state_q != IDLE) && (state_q != DONE);
    assign done_o      = (state_q == DONE);
    assign mem_req_o   = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign mem_we_o    = (state_q == WR_REQ);
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign sb_cnt_o    = sb_cnt_q;
    assign db_cnt_o    = db_cnt_q;
    assign db_addr_o   = db_addr_q;

endmodule

// File: doc/ecc_scrub_ctrl.md
ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

Interface
REQ-001 SHALL have parameter K, default 4, meaning data bits per word; codeword width CW = m+K+1, with m the smallest value satisfying 2**m >= m+K+1.
REQ-002 SHALL have parameter DEPTH, default 16, meaning words scrubbed per pass; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter CNT_W, default 8, meaning error counter width.
REQ-004 SHALL use one clock clk_i; reset rst_ni is asynchronous, active-low.
REQ-005 SHALL have ports, each as name direction width meaning:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- start_i  in  1  begin pass
- abort_i  in  1  end pass early
- busy_o  out  1  pass in progress
- done_o  out  1  one-cycle pass-complete pulse
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  AW  word address
- mem_wdata_o  out  CW  write codeword
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  CW  read codeword
- sb_cnt_o  out  CNT_W  corrected-error count
- db_cnt_o  out  CNT_W  uncorrectable-error count
- db_addr_o  out  AW  address of first uncorrectable word
- irq_o  out  1  uncorrectable-error interrupt

Function
REQ-006 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT, DONE.
REQ-007 IDLE: start_i=1 SHALL clear sb_cnt_o, db_cnt_o, db_addr_o and the address to 0, then go to RD_REQ; start_i SHALL be ignored in every other state.
REQ-008 RD_REQ/WR_REQ: mem_req_o=1, with mem_we_o, mem_addr_o and mem_wdata_o held stable until mem_gnt_i; on gnt, RD_REQ SHALL go to RD_WAIT and WR_REQ SHALL go to NEXT.
REQ-009 RD_WAIT: SHALL wait for mem_rvalid_i, capture mem_rdata_i into a register, then go to CHECK; mem_rvalid_i in any other state SHALL be ignored.
REQ-010 CHECK (one cycle, registered word decoded):
- single-bit error: sb_cnt++, then WR_REQ with the re-encoded corrected data.
- double-bit error: db_cnt++; db_addr_o = address if db_cnt was 0; then NEXT, with no write-back.
- clean word: NEXT.
REQ-011 NEXT: address DEPTH-1 SHALL go to DONE; otherwise address+1 and RD_REQ; the address SHALL never wrap within a pass.
REQ-012 DONE: done_o=1 for exactly one cycle, then IDLE.
REQ-013 busy_o SHALL be 1 in all states except IDLE and DONE.
REQ-014 Counters SHALL saturate at 2**CNT_W-1 and never wrap.
REQ-015 abort_i:
- in RD_REQ, CHECK or NEXT: go to DONE next cycle.
- in RD_WAIT: take the pending rvalid, update counters, skip write-back, then DONE.
- in WR_REQ: complete the write on gnt, then DONE.
- in IDLE or DONE: ignored.
- start_i and abort_i together in IDLE: start wins.
REQ-016 Timing with zero-wait memory (gnt same cycle, rvalid the cycle after gnt): a clean word SHALL take 4 cycles and a corrected word 5 cycles.

Reset
REQ-017 rst_ni low SHALL asynchronously force IDLE and drive every output to 0, including mem_req_o, counters, db_addr_o and irq_o.
REQ-018 Reset mid-pass SHALL drop any outstanding request without completing it.

Configuration
REQ-019 With ECC_SCRUB_IRQ_EN defined:
- irq_o SHALL be set on any double-bit detection.
- irq_o SHALL stay sticky until the next accepted start_i.
REQ-020 Without ECC_SCRUB_IRQ_EN, irq_o SHALL be tied 0 and the port SHALL remain present.

Structure
REQ-021 The FSM state enum and the calc-m function SHALL live in a shared package, ecc_pkg.
REQ-022 SHALL instantiate the existing hamming_dec (check) and hamming_enc (re-encode); no new sub-module.

Verification
REQ-023 DEPTH=16, all words clean, zero-wait memory: start_i at cycle 0 -> done_o at cycle 65, both counters 0, no writes.
REQ-024 Word 5 = encoding of 4'hA with one data bit flipped -> one write at address 5 with the clean encoding of 4'hA, sb_cnt_o=1.
REQ-025 Words 3 and 9 carry two-bit errors -> db_cnt_o=2, db_addr_o=3, no writes, and irq_o=1 only with ECC_SCRUB_IRQ_EN.
REQ-026 mem_gnt_i delayed 3 cycles and rvalid 2 cycles -> req/addr stable throughout, counts unchanged versus zero-wait.
REQ-027 abort_i during WR_REQ for word 7 -> write completes, done_o next, no read of address 8.
REQ-028 sb errors on 300 words (CNT_W=8, DEPTH=512) -> sb_cnt_o saturates at 255.
